// File: rtl/alien_swarm_mover_pkg.sv
// Shared definitions for the alien swarm mover and the zig-zag controller.
// Holds the motion command codes, the screen size used for default bounds,
// and the mover FSM state encodings.
package alien_swarm_mover_pkg;

  // Visible screen size in pixels; the default movement bounds derive from these.
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Motion command codes issued by the controller.
  typedef enum logic [1:0] {
    NO_MOTION = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2,
    DOWN      = 2'd3
  } motion_e;

  // Mover FSM states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MOVE = 1'b1;

endpackage

// File: rtl/alien_swarm_mover_bound_check.sv
// Combinational edge-of-playfield checks for the swarm bounding box.
// Ports: x, y (swarm top-left), dir (active command) in;
//        can_left, can_right, at_bottom, blocked (dir would cross a bound) out.
module alien_swarm_mover_bound_check
  import alien_swarm_mover_pkg::*;
#(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = SCREEN_W - 1,
  parameter int Y_MAX   = SCREEN_H - 1,
  parameter int SWARM_W = 256,
  parameter int SWARM_H = 128
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  motion_e        dir,
  output logic           can_left,
  output logic           can_right,
  output logic           at_bottom,
  output logic           blocked
);

  // One extra bit so the far edge (x + width - 1) can never wrap.
  localparam logic [X_W:0] X_MIN_C   = (X_W+1)'(X_MIN);
  localparam logic [X_W:0] X_MAX_C   = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] X_EDGE_C  = (X_W+1)'(SWARM_W - 1);
  localparam logic [Y_W:0] Y_MAX_C   = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] Y_EDGE_C  = (Y_W+1)'(SWARM_H - 1);

  logic [X_W:0] left_edge;
  logic [X_W:0] right_edge;
  logic [Y_W:0] bottom_edge;

  assign left_edge   = {1'b0, x};
  assign right_edge  = {1'b0, x} + X_EDGE_C;
  assign bottom_edge = {1'b0, y} + Y_EDGE_C;

  assign can_left  = left_edge > X_MIN_C;
  assign can_right = right_edge < X_MAX_C;
  assign at_bottom = bottom_edge == Y_MAX_C;

  always_comb begin
    blocked = 1'b0;
    case (dir)
      LEFT:    blocked = (left_edge == X_MIN_C);
      RIGHT:   blocked = (right_edge == X_MAX_C);
      DOWN:    blocked = at_bottom;
      default: blocked = 1'b0;
    endcase
  end

endmodule

// File: rtl/alien_swarm_mover.sv
// Executes controller motion commands one pixel per tick, tracking swarm position.
// Ports: clk, reset (sync, active-high), motion_valid/motion/tick in;
//        x, y, can_left, can_right, busy, reached_bottom, dropped out.
module alien_swarm_mover
  import alien_swarm_mover_pkg::*;
#(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = SCREEN_W - 1,
  parameter int Y_MAX   = SCREEN_H - 1,
  parameter int X_INIT  = 32,
  parameter int Y_INIT  = 48,
  parameter int SWARM_W = 256,
  parameter int SWARM_H = 128,
  parameter int H_STEP  = 8,
  parameter int V_STEP  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           motion_valid,
  input  logic [1:0]     motion,
  input  logic           tick,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           can_left,
  output logic           can_right,
  output logic           busy,
  output logic           reached_bottom,
  output logic           dropped
);

  localparam int STEP_MAX = (H_STEP > V_STEP) ? H_STEP : V_STEP;
  localparam int CNT_W    = $clog2(STEP_MAX + 1);

  localparam logic [CNT_W-1:0] H_CNT   = CNT_W'(H_STEP);
  localparam logic [CNT_W-1:0] V_CNT   = CNT_W'(V_STEP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [X_W-1:0]   X_ONE   = X_W'(1);
  localparam logic [Y_W-1:0]   Y_ONE   = Y_W'(1);

  logic [0:0]       state_q, state_d;
  motion_e          dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             dropped_q, dropped_d;
  logic             bottom_q, bottom_d;

  logic at_bottom;
  logic blocked;

  alien_swarm_mover_bound_check #(
    .X_W     (X_W),
    .Y_W     (Y_W),
    .X_MIN   (X_MIN),
    .X_MAX   (X_MAX),
    .Y_MAX   (Y_MAX),
    .SWARM_W (SWARM_W),
    .SWARM_H (SWARM_H)
  ) u_bound_check (
    .x         (x_q),
    .y         (y_q),
    .dir       (dir_q),
    .can_left  (can_left),
    .can_right (can_right),
    .at_bottom (at_bottom),
    .blocked   (blocked)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    x_d       = x_q;
    y_d       = y_q;
    dropped_d = 1'b0;
    bottom_d  = bottom_q | at_bottom;

    case (state_q)
      ST_IDLE: begin
        if (motion_valid && (motion_e'(motion) != NO_MOTION)) begin
          dir_d   = motion_e'(motion);
          rem_d   = (motion_e'(motion) == DOWN) ? V_CNT : H_CNT;
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        // A command arriving mid-move is discarded, not queued.
        dropped_d = motion_valid;
        if (tick) begin
          // Bound is checked before moving: a blocked swarm ends the command early.
          if (blocked) begin
            state_d = ST_IDLE;
          end else begin
            case (dir_q)
              LEFT:    x_d = x_q - X_ONE;
              RIGHT:   x_d = x_q + X_ONE;
              DOWN:    y_d = y_q + Y_ONE;
              default: ;
            endcase
            rem_d = rem_q - CNT_ONE;
            if (rem_q == CNT_ONE) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= NO_MOTION;
      rem_q     <= '0;
      x_q       <= X_W'(X_INIT);
      y_q       <= Y_W'(Y_INIT);
      dropped_q <= 1'b0;
      bottom_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      rem_q     <= rem_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dropped_q <= dropped_d;
      bottom_q  <= bottom_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign busy    = (state_q == ST_MOVE);
  assign dropped = dropped_q;
  // Raised in the same cycle y lands on the bottom row, then held by bottom_q.
  assign reached_bottom = bottom_q | at_bottom;

endmodule
